// File: rtl/inst_fetch_bridge_pkg.sv
// inst_fetch_bridge_pkg: shared FSM encoding, segment and exception constants, and the slot-split helper
package inst_fetch_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  localparam logic [1:0] KSEG01_SEG = 2'b10;
  localparam logic [4:0] EXC_ADEL   = 5'h04;
  localparam logic [4:0] EXC_IBE    = 5'h06;

  // Returns {slot2, slot1}. An odd-word pc (pc[2]=1) uses only the upper word, and slot 2 becomes a nop.
  function automatic logic [63:0] slot_pair(input logic hi, input logic [63:0] d);
    return hi ? {32'h0, d[63:32]} : d;
  endfunction

endpackage

// File: rtl/inst_fetch_bridge_fetch_line_buf.sv
// fetch_line_buf: one-entry buffer of the last completed fetch line (tag, data, err)
//   clk, reset      clock, asynchronous active-low reset (clears valid)
//   wr_i            capture wr_tag_i/wr_data_i/wr_err_i as the valid entry
//   inv_i           invalidate the entry (takes priority over wr_i)
//   rd_tag_i        lookup tag; hit_o = valid & tag match
//   rd_data_o       buffered 64-bit line, rd_err_o buffered error flag
import inst_fetch_bridge_pkg::*;

module fetch_line_buf #(
  parameter int TAG_W = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic             inv_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [63:0]      wr_data_i,
  input  logic             wr_err_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             hit_o,
  output logic [63:0]      rd_data_o,
  output logic             rd_err_o
);

  logic             vld_q;
  logic [TAG_W-1:0] tag_q;
  logic [63:0]      data_q;
  logic             err_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (inv_i) begin
      vld_q <= 1'b0;
    end else if (wr_i) begin
      vld_q  <= 1'b1;
      tag_q  <= wr_tag_i;
      data_q <= wr_data_i;
      err_q  <= wr_err_i;
    end

  assign hit_o     = vld_q & (tag_q == rd_tag_i);
  assign rd_data_o = data_q;
  assign rd_err_o  = err_q;

endmodule

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: IF-stage fetch responder issuing one 64-bit read per new pc and returning the instruction pair
//   clk, reset          clock, asynchronous active-low reset
//   pc, pcn, flush      fetch address, new-pc strobe, redirect/cancel from IF
//   inst_req/addr       bus request and 8-byte aligned physical address, held until inst_addr_ok
//   inst_rdata/data_ok  read data ([31:0] word at pc, [63:32] word at pc+4), inst_err bus error
//   if_inst, if_inst_2  slot-1/slot-2 instructions, held until the next response
//   inst_valid          one-cycle pulse; IADEE/IADFE exception flags valid with it
//   delay_hard          combinational stall request to IF
//   INST_FETCH_BUF_EN   when defined, adds a one-entry line buffer that answers repeat fetches without the bus
import inst_fetch_bridge_pkg::*;

module inst_fetch_bridge #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] KSEG_MASK = 32'h1fff_ffff
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pcn,
  input  logic              flush,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic [63:0]       inst_rdata,
  input  logic              inst_data_ok,
  input  logic              inst_err,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_inst_2,
  output logic              inst_valid,
  output logic              delay_hard,
  output logic              IADEE,
  output logic              IADFE
);

  state_e            state_q;
  logic              pc2_q;
  logic              aligned;
  logic              hit;
  logic              buf_err;
  logic [63:0]       buf_data;
  logic [ADDR_W-1:0] phys;

  assign aligned = pc[1:0] == 2'b00;
  // kseg0/kseg1 fold onto the same physical window; everything else is identity-mapped
  assign phys    = (pc[ADDR_W-1 -: 2] == KSEG01_SEG ? pc & KSEG_MASK : pc) & ~ADDR_W'(7);

`ifdef INST_FETCH_BUF_EN
  logic              done;
  logic [ADDR_W-4:0] tag_q;

  // only an unflushed completion updates the buffer; an erroring one must not be replayed
  assign done = (state_q == WAIT) & inst_data_ok & ~flush;

  always_ff @(posedge clk or negedge reset)
    if (!reset)
      tag_q <= '0;
    else if (state_q == IDLE && pcn && aligned && !hit)
      tag_q <= pc[ADDR_W-1:3];

  fetch_line_buf #(
    .TAG_W(ADDR_W-3)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (done & ~inst_err),
    .inv_i    (done & inst_err),
    .wr_tag_i (tag_q),
    .wr_data_i(inst_rdata),
    .wr_err_i (inst_err),
    .rd_tag_i (pc[ADDR_W-1:3]),
    .hit_o    (hit),
    .rd_data_o(buf_data),
    .rd_err_o (buf_err)
  );
`else
  assign hit      = 1'b0;
  assign buf_data = '0;
  assign buf_err  = 1'b0;
`endif

  assign delay_hard = (state_q != IDLE) | (pcn & aligned & ~hit);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      pc2_q      <= 1'b0;
      inst_req   <= 1'b0;
      inst_addr  <= '0;
      if_inst    <= '0;
      if_inst_2  <= '0;
      inst_valid <= 1'b0;
      IADEE      <= 1'b0;
      IADFE      <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      case (state_q)
        IDLE:
          if (pcn) begin
            if (!aligned) begin
              inst_valid <= 1'b1;
              IADEE      <= 1'b1;
              IADFE      <= 1'b0;
              if_inst    <= '0;
              if_inst_2  <= '0;
            end else if (hit) begin
              inst_valid             <= 1'b1;
              IADEE                  <= 1'b0;
              IADFE                  <= buf_err;
              {if_inst_2, if_inst}   <= slot_pair(pc[2], buf_data);
            end else begin
              pc2_q     <= pc[2];
              inst_req  <= 1'b1;
              inst_addr <= phys;
              state_q   <= REQ;
            end
          end
        REQ:
          // once the address is accepted a response is owed, so a late flush must still drain it
          if (inst_addr_ok) begin
            inst_req <= 1'b0;
            state_q  <= flush ? DISCARD : WAIT;
          end else if (flush) begin
            inst_req <= 1'b0;
            state_q  <= IDLE;
          end
        WAIT:
          if (inst_data_ok) begin
            state_q <= IDLE;
            if (!flush) begin
              inst_valid           <= 1'b1;
              IADEE                <= 1'b0;
              IADFE                <= inst_err;
              {if_inst_2, if_inst} <= slot_pair(pc2_q, inst_rdata);
            end
          end else if (flush) begin
            state_q <= DISCARD;
          end
        DISCARD:
          if (inst_data_ok)
            state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: randomized self-checking bench with a transaction-level model of the fetch bridge
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        pcn = 1'b0;
  logic        flush = 1'b0;
  logic        inst_addr_ok = 1'b0;
  logic [63:0] inst_rdata = '0;
  logic        inst_data_ok = 1'b0;
  logic        inst_err = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] if_inst;
  logic [31:0] if_inst_2;
  logic        inst_valid;
  logic        delay_hard;
  logic        IADEE;
  logic        IADFE;

  int total = 0;
  int bad = 0;

  logic        ref_vld = 1'b0;
  logic [28:0] ref_tag = '0;
  logic [63:0] ref_data = '0;

  logic [31:0] pool [5] = '{32'h8000_0000, 32'h8000_0008, 32'ha000_0010, 32'h0040_0000, 32'hbfc0_0004};

  always #5 clk = ~clk;

  inst_fetch_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pcn         (pcn),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_rdata  (inst_rdata),
    .inst_data_ok(inst_data_ok),
    .inst_err    (inst_err),
    .if_inst     (if_inst),
    .if_inst_2   (if_inst_2),
    .inst_valid  (inst_valid),
    .delay_hard  (delay_hard),
    .IADEE       (IADEE),
    .IADFE       (IADFE)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
    logic [31:0] m;
    m = (a >= 32'h8000_0000 && a < 32'hc000_0000) ? a - (a & 32'he000_0000) : a;
    return m - (m % 8);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] a, input logic [63:0] d);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  function automatic logic [31:0] s2(input logic [31:0] a, input logic [63:0] d);
    return a[2] ? 32'h0 : d[63:32];
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
`ifdef INST_FETCH_BUF_EN
    return a[1:0] == 2'b00 && ref_vld && ref_tag == a[31:3];
`else
    return 1'b0;
`endif
  endfunction

  // one full fetch: wa cycles of address stall, wd cycles of data latency
  task automatic fetch(input logic [31:0] a, input int wa, input int wd, input logic [63:0] d, input logic e);
    logic hit;
    logic mis;
    hit = exp_hit(a);
    mis = a[1:0] != 2'b00;
    step();
    pc = a;
    pcn = 1'b1;
    #2;
    chk("dh_accept", delay_hard, !mis && !hit);
    step();
    pcn = 1'b0;
    #2;
    if (mis || hit) begin
      chk("v_fast", inst_valid, 1'b1);
      chk("adee_fast", IADEE, mis);
      chk("req_fast", inst_req, 1'b0);
      chk("dh_fast", delay_hard, 1'b0);
      chk("slot1_fast", if_inst, mis ? 32'h0 : s1(a, ref_data));
      chk("slot2_fast", if_inst_2, mis ? 32'h0 : s2(a, ref_data));
      if (hit)
        chk("adfe_hit", IADFE, 1'b0);
      step();
      #2;
      chk("v_fast_pulse", inst_valid, 1'b0);
      chk("req_fast2", inst_req, 1'b0);
      return;
    end
    for (int i = 0; i <= wa; i++) begin
      if (i > 0)
        step();
      pcn = (i < wa) ? 1'($urandom_range(0, 1)) : 1'b0;
      pc = pcn ? $urandom : a;
      inst_addr_ok = i == wa;
      #2;
      chk("req", inst_req, 1'b1);
      chk("addr", inst_addr, exp_addr(a));
      chk("dh_req", delay_hard, 1'b1);
      chk("v_req", inst_valid, 1'b0);
    end
    step();
    inst_addr_ok = 1'b0;
    pcn = 1'b0;
    pc = a;
    for (int i = 0; i <= wd; i++) begin
      if (i > 0)
        step();
      inst_data_ok = i == wd;
      inst_rdata = d;
      inst_err = e;
      #2;
      chk("req_drop", inst_req, 1'b0);
      chk("dh_wait", delay_hard, 1'b1);
      chk("v_wait", inst_valid, 1'b0);
    end
    step();
    inst_data_ok = 1'b0;
    inst_err = 1'b0;
    inst_rdata = {$urandom, $urandom};
    #2;
    chk("v_resp", inst_valid, 1'b1);
    chk("slot1", if_inst, s1(a, d));
    chk("slot2", if_inst_2, s2(a, d));
    chk("adfe", IADFE, e);
    chk("adee", IADEE, 1'b0);
    chk("dh_done", delay_hard, 1'b0);
    if (e)
      ref_vld = 1'b0;
    else begin
      ref_vld = 1'b1;
      ref_tag = a[31:3];
      ref_data = d;
    end
    step();
    #2;
    chk("v_pulse", inst_valid, 1'b0);
    chk("slot1_hold", if_inst, s1(a, d));
  endtask

  // mode 0: flush while awaiting addr_ok; 1: flush in WAIT, data lat cycles later; 2: flush with data_ok
  task automatic fetch_flush(input logic [31:0] a0, input int mode, input int lat);
    logic [31:0] a;
    a = a0;
    a[1:0] = 2'b00;
    if (exp_hit(a))
      a = a ^ 32'h100;
    step();
    pc = a;
    pcn = 1'b1;
    #2;
    chk("dh_f_acc", delay_hard, 1'b1);
    step();
    pcn = 1'b0;
    if (mode == 0) begin
      flush = 1'b1;
      #2;
      chk("req_pre_f", inst_req, 1'b1);
      step();
      flush = 1'b0;
      #2;
      chk("req_post_f", inst_req, 1'b0);
      chk("dh_post_f", delay_hard, 1'b0);
      chk("v_post_f", inst_valid, 1'b0);
      return;
    end
    inst_addr_ok = 1'b1;
    #2;
    step();
    inst_addr_ok = 1'b0;
    flush = 1'b1;
    inst_data_ok = mode == 2;
    inst_rdata = {$urandom, $urandom};
    #2;
    chk("dh_f_wait", delay_hard, 1'b1);
    step();
    flush = 1'b0;
    inst_data_ok = 1'b0;
    if (mode == 2) begin
      #2;
      chk("v_f_same", inst_valid, 1'b0);
      chk("dh_f_same", delay_hard, 1'b0);
    end else begin
      for (int i = 0; i <= lat; i++) begin
        if (i > 0)
          step();
        inst_data_ok = i == lat;
        pcn = i < lat;
        pc = a ^ 32'h8;
        #2;
        chk("dh_discard", delay_hard, 1'b1);
        chk("v_discard", inst_valid, 1'b0);
      end
    end
    step();
    inst_data_ok = 1'b0;
    pcn = 1'b0;
    #2;
    chk("v_dropped", inst_valid, 1'b0);
    chk("dh_back_idle", delay_hard, 1'b0);
    chk("req_back_idle", inst_req, 1'b0);
  endtask

  task automatic reset_mid();
    step();
    pc = 32'h0040_0100;
    pcn = 1'b1;
    #2;
    step();
    pcn = 1'b0;
    #2;
    chk("req_pre_rst", inst_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_async_req", inst_req, 1'b0);
    chk("rst_async_dh", delay_hard, 1'b0);
    step();
    reset = 1'b1;
    ref_vld = 1'b0;
    step();
    inst_data_ok = 1'b1;
    inst_rdata = {$urandom, $urandom};
    #2;
    chk("dh_rst_data", delay_hard, 1'b0);
    step();
    inst_data_ok = 1'b0;
    #2;
    chk("v_rst_data", inst_valid, 1'b0);
    chk("req_rst_data", inst_req, 1'b0);
  endtask

  initial begin
    #3;
    chk("rst_req", inst_req, 1'b0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_inst2", if_inst_2, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_adee", IADEE, 1'b0);
    chk("rst_adfe", IADFE, 1'b0);
    chk("rst_dh", delay_hard, 1'b0);
    reset = 1'b1;

    fetch(32'hbfc0_0000, 0, 0, 64'h2402_0001_3c01_bfc0, 1'b0);
    chk("basic_slot1", if_inst, 32'h3c01_bfc0);
    chk("basic_slot2", if_inst_2, 32'h2402_0001);
    fetch(32'hbfc0_0002, 0, 0, 64'h0, 1'b0);
    fetch_flush(32'h0040_0020, 1, 3);
    fetch(32'h0040_0020, 0, 1, 64'h1111_2222_3333_4444, 1'b0);
    fetch(32'h8000_0040, 1, 0, 64'hdead_beef_cafe_f00d, 1'b1);
    fetch(32'h8000_0040, 0, 0, 64'h0123_4567_89ab_cdef, 1'b0);
    fetch(32'ha000_1000, 5, 2, 64'h5555_6666_7777_8888, 1'b0);
    fetch(32'h8000_0010, 0, 0, 64'h0bad_0001_0bad_0002, 1'b0);
    fetch(32'h8000_0010, 0, 0, 64'h0, 1'b0);
    fetch(32'h8000_0014, 2, 1, 64'hfeed_0004_feed_0000, 1'b0);
    fetch_flush(32'h0040_0200, 0, 0);
    fetch_flush(32'h0040_0300, 2, 0);
    reset_mid();

    for (int n = 0; n < 150; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0)
        a = a | 32'($urandom_range(1, 7));
      if (op <= 6)
        fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      else if (op <= 8)
        fetch_flush(a, $urandom_range(0, 2), $urandom_range(0, 3));
      else
        reset_mid();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Responder side of the fetch interface for the dual-issue IF stage.
- Accepts a fetch PC plus a new-PC strobe and issues one 64-bit read (two instructions at pc and pc+4) on the instruction SRAM-like bus.
- Returns the instruction pair, and raises delay_hard while the transaction is outstanding.
- Reports address-error (IADEE) and bus-fault (IADFE) exceptions, and drops in-flight responses on pipeline flush.

Parameters:
- ADDR_W, 32, fetch/bus address width.
- KSEG_MASK, 32'h1fff_ffff, virtual-to-physical mask applied to kseg0/kseg1 addresses.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- pc  in  ADDR_W  fetch address from IF
- pcn  in  1  new-PC strobe; pc valid this cycle
- flush  in  1  redirect (branch/jump/interrupt/if_cln); cancel current fetch
- inst_req  out  1  bus request
- inst_addr  out  ADDR_W  physical bus address, 8-byte aligned
- inst_addr_ok  in  1  bus accepted address
- inst_rdata  in  64  [31:0] = word at pc, [63:32] = word at pc+4
- inst_data_ok  in  1  read data valid
- inst_err  in  1  bus error, qualified by inst_data_ok
- if_inst  out  32  slot-1 instruction
- if_inst_2  out  32  slot-2 instruction
- inst_valid  out  1  one-cycle pulse; pair valid
- delay_hard  out  1  stall request to IF
- IADEE  out  1  address-error exception flag, valid with inst_valid
- IADFE  out  1  bus-fault exception flag, valid with inst_valid

Behaviour:
- Reset values:
  - Outputs: inst_req=0, inst_addr=0, if_inst=0, if_inst_2=0, inst_valid=0, IADEE=0, IADFE=0, delay_hard=0.
  - State=IDLE.
  - Reset mid-transaction abandons it. Any later data_ok is ignored because the state is IDLE.
- Address mapping: if pc[31:30]==2'b10, inst_addr = pc & KSEG_MASK; otherwise pc passes through. inst_addr[2:0] is forced to 0.
- FSM states: IDLE, REQ, WAIT, DISCARD.
- IDLE:
  - On pcn with pc[1:0]!=0: no bus request. Next cycle: inst_valid=1, IADEE=1, if_inst/if_inst_2=0. Stay IDLE.
  - On pcn with pc aligned: latch pc and go to REQ.
  - pc[2]=1 is legal. The returned slot-1 word is rdata[63:32] and if_inst_2 is 0 (nop).
- REQ:
  - inst_req=1 and inst_addr are held stable until inst_addr_ok. Then go to WAIT.
  - flush before addr_ok: drop inst_req and go to IDLE; no response.
- WAIT:
  - On inst_data_ok: register data into if_inst/if_inst_2; inst_valid=1 next cycle; IADFE=inst_err; go to IDLE.
  - flush (and no data_ok the same cycle): go to DISCARD.
  - flush in the same cycle as data_ok: flush wins. Data is dropped, inst_valid stays 0, go to IDLE.
- DISCARD: wait for inst_data_ok, drop it, go to IDLE. pcn is not accepted in this state.
- delay_hard = (state!=IDLE) | (pcn & aligned & state==IDLE), combinational.
- One outstanding transaction maximum. pcn outside IDLE is ignored; IF re-presents pc because it holds next_pc<=pc while stalled.
- Minimum latency: pcn@T, req@T+1, addr_ok@T+1, data_ok@T+2, inst_valid@T+3.
- inst_valid is a single-cycle pulse. if_inst/if_inst_2 hold their value until the next response.

Optional Feature:
- Macro: INST_FETCH_BUF_EN.
- When defined:
  - A one-entry buffer holds {tag=pc[31:3], data, err} of the last completed fetch.
  - pcn hitting the valid tag in IDLE gives inst_valid the next cycle with no bus request, and delay_hard=0.
  - The buffer is invalidated on reset and on any completion with inst_err=1.
  - flush does not invalidate the buffer.
- When undefined: every pcn causes a bus transaction.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DISCARD=2'd3).
  - KSEG segment constants.
  - Exception code constants for ADEL-instruction and IBE.
- Sub-module fetch_line_buf holds the INST_FETCH_BUF_EN buffer: tag compare, data, valid, and invalidate port. It is instantiated only under the macro.

Test Plan:
- Basic fetch: pc=32'hbfc0_0000 pcn; addr_ok and data_ok after 1 cycle each, rdata=64'h2402_0001_3c01_bfc0. Required:
  - inst_addr=32'h1fc0_0000.
  - if_inst=32'h3c01_bfc0, if_inst_2=32'h2402_0001.
  - inst_valid one pulse at T+3; delay_hard high T..T+2.
- Misaligned: pc=32'hbfc0_0002 pcn -> no inst_req; IADEE=1 and inst_valid=1 next cycle; if_inst=0.
- Flush in WAIT: issue fetch, flush before data_ok, then data_ok 3 cycles later -> no inst_valid; state returns to IDLE after data_ok; the next pcn is served normally.
- Bus error: data_ok with inst_err=1 -> IADFE=1 with inst_valid. With INST_FETCH_BUF_EN, a repeat of the same pc then issues a new bus request.
- Stalled bus: addr_ok held low 5 cycles -> inst_req/inst_addr stable throughout; pcn pulses with other pc values are ignored; delay_hard=1.
- INST_FETCH_BUF_EN hit: fetch pc=32'h8000_0010, then pcn again with the same pc -> inst_valid next cycle, inst_req stays 0, same data returned.
